// File: rtl/canny_pkg.sv
// Shared image constants and arbiter state encoding for the Canny pipeline's
// SRAM-facing blocks.
package canny_pkg;

  localparam int IMG_W    = 512;
  localparam int IMG_H    = 512;
  localparam int ADDR_W   = $clog2(IMG_W * IMG_H);
  localparam int DATA_W   = 8;
  localparam int STREAK_W = 4;
  localparam int LAT_W    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lat_counter.sv
// Read-latency countdown: loaded when a read is issued, done in the cycle whose
// closing edge must capture the SRAM read data.
module lat_counter #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic count,
  output logic done
);
  import canny_pkg::*;

  logic [LAT_W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAT_W'(RD_LAT);
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == LAT_W'(1));

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a pixel-fetch read port and a write-controller port onto one
// single-ported SRAM with fixed read latency and bounded write starvation.
module sram_arbiter #(
  parameter int ADDR_W       = canny_pkg::ADDR_W,
  parameter int DATA_W       = canny_pkg::DATA_W,
  parameter int RD_LAT       = 2,
  parameter int MAX_WR_BURST = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);
  import canny_pkg::*;

  localparam logic [STREAK_W-1:0] BURST_LIMIT = STREAK_W'(MAX_WR_BURST);
  localparam logic [STREAK_W-1:0] STREAK_SAT  = '1;

  arb_state_t          state, state_nx;
  logic [STREAK_W-1:0] streak;
  logic                issue_wr, issue_rd, capture;
  logic                lat_count, lat_done;

  assign lat_count = (state == READ_WAIT);

  lat_counter #(.RD_LAT(RD_LAT)) u_lat_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (issue_rd),
    .count (lat_count),
    .done  (lat_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nx = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        // Write has priority until it has starved a waiting read for a full burst.
        if (wr_req && !(rd_req && streak == BURST_LIMIT)) begin
          issue_wr = 1'b1;
          state_nx = WRITE;
        end else if (rd_req) begin
          issue_rd = 1'b1;
          state_nx = READ_WAIT;
        end
      end
      WRITE: state_nx = IDLE;
      READ_WAIT: begin
        if (lat_done) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset as well, because rd_data and the
  // SRAM bus are observable and must read 0 out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_gnt     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      wr_gnt     <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      busy       <= 1'b0;
      streak     <= '0;
    end else begin
      rd_gnt   <= issue_rd;
      sram_re  <= issue_rd;
      wr_gnt   <= issue_wr;
      sram_we  <= issue_wr;
      rd_valid <= capture;
      busy     <= (state_nx != IDLE);

      if (issue_wr) begin
        sram_addr  <= wr_addr;
        sram_wdata <= wr_data;
      end else if (issue_rd) begin
        sram_addr  <= rd_addr;
      end

      if (capture) rd_data <= sram_rdata;

      // Streak only measures how long a waiting read has been held off.
      if (!rd_req || issue_rd) begin
        streak <= '0;
      end else if (issue_wr && streak != STREAK_SAT) begin
        streak <= streak + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter against a cycle-schedule
// reference model and a behavioural SRAM with fixed read latency.
module tb_sram_arbiter;

  localparam int ADDR_W       = 18;
  localparam int DATA_W       = 8;
  localparam int RD_LAT       = 2;
  localparam int MAX_WR_BURST = 4;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_gnt, rd_valid, wr_gnt, sram_we, sram_re, busy;
  logic [DATA_W-1:0] rd_data, sram_wdata, sram_rdata;
  logic [ADDR_W-1:0] sram_addr;

  int n_pass  = 0;
  int n_total = 0;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WR_BURST(MAX_WR_BURST)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_re(sram_re),
    .sram_rdata(sram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural SRAM ----------------
  logic [DATA_W-1:0] sram_mem [int];
  logic [DATA_W-1:0] rd_pipe [1:RD_LAT-1];

  function automatic logic [DATA_W-1:0] fill(input int a);
    return DATA_W'(a * 37 + 11) ^ DATA_W'(a >> 8);
  endfunction

  function automatic logic [DATA_W-1:0] env_read(input int a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return fill(a);
  endfunction

  always @(posedge clk) begin
    rd_pipe[1] <= sram_re ? env_read(int'(sram_addr)) : '0;
    for (int i = 2; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  // Every grant books the port until a given edge; a read also books the
  // edge at which its data is delivered.
  logic [DATA_W-1:0] ref_mem [int];
  int edge_no, free_edge, valid_edge, busy_last, streak_m;
  logic [DATA_W-1:0] valid_data;
  logic e_rd_gnt, e_rd_valid, e_wr_gnt, e_we, e_re, e_busy;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;

  function automatic logic [DATA_W-1:0] ref_read(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  task automatic model_reset();
    edge_no = 0; free_edge = 0; valid_edge = -1; busy_last = -1; streak_m = 0;
    {e_rd_gnt, e_rd_valid, e_wr_gnt, e_we, e_re, e_busy} = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  // Called with the inputs that the coming rising edge will see.
  task automatic model_edge();
    if (!n_rst) begin
      model_reset();
      return;
    end
    edge_no++;
    {e_rd_gnt, e_wr_gnt, e_we, e_re} = '0;
    e_rd_valid = (edge_no == valid_edge);
    if (e_rd_valid) e_rdata = valid_data;
    if (edge_no >= free_edge) begin
      if (wr_req && !(rd_req && streak_m == MAX_WR_BURST)) begin
        e_wr_gnt = 1'b1; e_we = 1'b1;
        e_addr = wr_addr; e_wdata = wr_data;
        ref_mem[int'(wr_addr)] = wr_data;
        free_edge = edge_no + 2;
        busy_last = edge_no;
        if (rd_req && streak_m < 15) streak_m++;
      end else if (rd_req) begin
        e_rd_gnt = 1'b1; e_re = 1'b1;
        e_addr = rd_addr;
        valid_edge = edge_no + RD_LAT;
        valid_data = ref_read(int'(rd_addr));
        free_edge = edge_no + RD_LAT + 1;
        busy_last = edge_no + RD_LAT - 1;
        streak_m = 0;
      end
    end
    if (!rd_req) streak_m = 0;
    e_busy = (edge_no <= busy_last);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_outputs();
    check("strobes", 32'({rd_gnt, rd_valid, wr_gnt, sram_we, sram_re, busy}),
          32'({e_rd_gnt, e_rd_valid, e_wr_gnt, e_we, e_re, e_busy}));
    check("sram_addr", 32'(sram_addr), 32'(e_addr));
    check("sram_wdata", 32'(sram_wdata), 32'(e_wdata));
    check("rd_data", 32'(rd_data), 32'(e_rdata));
    check("we_re_exclusive", 32'(sram_we & sram_re), 32'd0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive_random();
    if (rd_req && rd_gnt)                          rd_req = 1'b0;
    else if (rd_req && $urandom_range(0, 19) == 0) rd_req = 1'b0;
    else if (!rd_req && $urandom_range(0, 2) == 0) begin
      rd_req  = 1'b1;
      rd_addr = ADDR_W'($urandom_range(0, 63));
    end
    if (wr_req && wr_gnt)                          wr_req = 1'b0;
    else if (wr_req && $urandom_range(0, 19) == 0) wr_req = 1'b0;
    else if (!wr_req && $urandom_range(0, 2) == 0) begin
      wr_req  = 1'b1;
      wr_addr = ADDR_W'($urandom_range(0, 63));
      wr_data = DATA_W'($urandom);
    end
  endtask

  initial begin
    int   n_gnt, n_valid;
    bit   order_q[$];
    logic [9:0] order;

    // Power-on reset
    #1 n_rst = 1'b0;
    #1 model_reset();
    compare_outputs();
    @(negedge clk);
    tick();
    tick();
    n_rst = 1'b1;

    // Single read of a preloaded word
    sram_mem[5] = 8'hA5;
    ref_mem[5]  = 8'hA5;
    rd_req = 1'b1; rd_addr = 18'h00005;
    tick();
    check("read rd_gnt@1", 32'(rd_gnt), 32'd1);
    check("read sram_re@1", 32'(sram_re), 32'd1);
    check("read addr@1", 32'(sram_addr), 32'h5);
    rd_req = 1'b0;
    tick();
    check("read rd_valid@2", 32'(rd_valid), 32'd0);
    tick();
    check("read rd_valid@3", 32'(rd_valid), 32'd1);
    check("read rd_data@3", 32'(rd_data), 32'hA5);
    tick();

    // Single write at the top of the address space
    wr_req = 1'b1; wr_addr = 18'h3FFFF; wr_data = 8'hFF;
    tick();
    check("write strobes", 32'({wr_gnt, sram_we, busy}), 32'b111);
    check("write addr", 32'(sram_addr), 32'h3FFFF);
    check("write data", 32'(sram_wdata), 32'hFF);
    wr_req = 1'b0;
    tick();
    check("write busy released", 32'({wr_gnt, sram_we, busy}), 32'b000);
    check("write addr held", 32'(sram_addr), 32'h3FFFF);

    // Write request held with no read: grant every second cycle
    wr_req = 1'b1; wr_addr = 18'h00100; wr_data = 8'h3C;
    n_gnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_gnt) n_gnt++;
    end
    check("held write grant count", 32'(n_gnt), 32'd5);
    wr_req = 1'b0;
    tick();

    // Both requests held: bounded write burst, then the read
    wr_req = 1'b1; rd_req = 1'b1; rd_addr = 18'h00100;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wr_gnt) order_q.push_back(1'b1);
      if (rd_gnt) order_q.push_back(1'b0);
    end
    order = '0;
    for (int i = 0; i < 10 && i < order_q.size(); i++) order[9-i] = order_q[i];
    check("contention grant count", 32'(order_q.size() >= 10), 32'd1);
    check("contention grant order", 32'(order), 32'b1111011110);
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset in the middle of a read wait
    rd_req = 1'b1; rd_addr = 18'h00005;
    tick();
    check("abort rd_gnt", 32'(rd_gnt), 32'd1);
    rd_req = 1'b0;
    tick();
    n_rst = 1'b0;
    #1 model_reset();
    check("abort outputs cleared",
          32'({rd_gnt, rd_valid, wr_gnt, sram_we, sram_re, busy, |sram_addr, |sram_wdata, |rd_data}),
          32'd0);
    compare_outputs();
    @(negedge clk);
    tick();
    n_rst = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_valid) n_valid++;
    end
    check("abort no rd_valid", 32'(n_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
